// File: rtl/rv_pkg.sv
// Shared fetch-stage types and constants: datapath width, reset vector default, FSM encoding.
package rv_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned CountWidth   = 32;
  localparam int unsigned InstrBytes   = 4;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds pc/instr with a valid bit; flush wins over load, otherwise holds.
module if_id_reg
  import rv_pkg::*;
#(
  parameter int unsigned Width = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             flush,
  input  logic [Width-1:0] pc_in,
  input  logic [Width-1:0] instr_in,
  output logic             valid,
  output logic [Width-1:0] pc,
  output logic [Width-1:0] instr
);

  logic             valid_d, valid_q;
  logic [Width-1:0] pc_d, pc_q;
  logic [Width-1:0] instr_d, instr_q;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC with redirect, IF/ID handshake to decode,
// sticky halt on a misaligned redirect target.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned      Width       = XLEN,
  parameter logic [Width-1:0] ResetVector = Width'(RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [Width-1:0]      imem_address,
  output logic                  imem_valid,
  input  logic [Width-1:0]      imem_data,
  input  logic                  redirect_valid,
  input  logic [Width-1:0]      redirect_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Width-1:0]      out_pc,
  output logic [Width-1:0]      out_instr,
  output logic                  fault,
  output logic [CountWidth-1:0] fetch_count
);

  fetch_state_e          state_d, state_q;
  logic [Width-1:0]      pc_d, pc_q;
  logic                  fault_d, fault_q;
  logic [CountWidth-1:0] fetch_count_d, fetch_count_q;
  logic                  fetch_en;
  logic                  ifid_load;
  logic                  ifid_flush;

  // A fetch happens only when the IF/ID slot is free or draining this cycle.
  assign fetch_en = (state_q == FETCH_RUN) && (!out_valid || out_ready) && !redirect_valid;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_RUN;
        if (redirect_valid) begin
          if (is_misaligned(redirect_target[1:0])) begin
            fault_d = 1'b1;
            state_d = FETCH_HALTED;
          end else begin
            pc_d = redirect_target;
          end
        end
      end
      FETCH_RUN: begin
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          if (is_misaligned(redirect_target[1:0])) begin
            fault_d = 1'b1;
            state_d = FETCH_HALTED;
          end else begin
            pc_d = redirect_target;
          end
        end else if (fetch_en) begin
          ifid_load     = 1'b1;
          pc_d          = pc_q + Width'(InstrBytes);
          fetch_count_d = fetch_count_q + CountWidth'(1);
        end else if (out_ready) begin
          ifid_flush = 1'b1;
        end
      end
      FETCH_HALTED: begin
        ifid_flush = 1'b1;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= ResetVector;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .Width(Width)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .pc_in   (pc_q),
    .instr_in(imem_data),
    .valid   (out_valid),
    .pc      (out_pc),
    .instr   (out_instr)
  );

  assign imem_address = pc_q;
  assign imem_valid   = fetch_en;
  assign fault        = fault_q;
  assign fetch_count  = fetch_count_q;

endmodule
